// File: rtl/if_id_fetch_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry circular buffer of (pc, inst)
// pairs delivered in program order, emptied by a control-flow redirect (flush).
module if_id_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic              push, pop;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high. Ready depends only on registered state, so a pop never frees a slot
  // for a push in the same cycle, and a push is dropped while flush is high.
  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  assign out_pc   = out_valid ? pc_mem[rd_ptr_q]   : '0;
  assign out_inst = out_valid ? inst_mem[rd_ptr_q] : '0;
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // A pop in this cycle still hands the head to decode; everything else goes.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_ptr_q]   <= in_pc;
      inst_mem[wr_ptr_q] <= in_inst;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    (count_q == FULL_CNT) |-> !push);
  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
    (count_q == '0) |-> !pop);
  a_count_in_range: assert property (@(posedge clk) disable iff (rst)
    count_q <= FULL_CNT);

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Bench for if_id_fetch_queue: directed vector table, hand sequences for flush,
// streaming and reset, then random traffic against a queue-based reference.
module tb_if_id_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 64;
  localparam int INST_W = 32;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam logic [63:0] B = 64'h8000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc = '0;
  logic [INST_W-1:0] in_inst = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [CW-1:0]     count;

  if_id_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .count(count)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [PC_W+INST_W-1:0] exp_q[$];
  logic last_push;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Applies the queue rules to the inputs present at this edge.
  task automatic model_edge();
    logic acc, take;
    acc  = 1'b0;
    take = 1'b0;
    if (rst) begin
      exp_q.delete();
    end else begin
      acc  = in_valid && (exp_q.size() < DEPTH) && !flush;
      take = (exp_q.size() != 0) && out_ready;
      if (flush) exp_q.delete();
      else begin
        if (take) void'(exp_q.pop_front());
        if (acc)  exp_q.push_back({in_pc, in_inst});
      end
    end
    last_push = acc;
  endtask

  task automatic check_model(input string tag);
    logic [PC_W-1:0]   e_pc;
    logic [INST_W-1:0] e_inst;
    e_pc   = '0;
    e_inst = '0;
    if (exp_q.size() != 0) {e_pc, e_inst} = exp_q[0];
    chk({tag, " out_valid"}, 64'(out_valid), 64'(exp_q.size() != 0));
    chk({tag, " in_ready"},  64'(in_ready),  64'(exp_q.size() < DEPTH));
    chk({tag, " count"},     64'(count),     64'(exp_q.size()));
    chk({tag, " out_pc"},    out_pc,         e_pc);
    chk({tag, " out_inst"},  64'(out_inst),  64'(e_inst));
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return pc[31:0] - 32'h8000_0000 + 32'h0000_0413;
  endfunction

  task automatic drive(input logic r, f, iv, input logic [63:0] pc, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_inst = inst_of(pc); out_ready = ordy;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic chk_out(input string tag, input logic ev, er, input int ec, input logic [63:0] epc);
    chk({tag, " out_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, " in_ready"},  64'(in_ready),  64'(er));
    chk({tag, " count"},     64'(count),     64'(ec));
    chk({tag, " out_pc"},    out_pc,         epc);
    chk({tag, " out_inst"},  64'(out_inst),  ev ? 64'(inst_of(epc)) : 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, flush, in_valid;
    logic [63:0] pc;
    logic        out_ready;
    logic        exp_valid, exp_ready;
    int          exp_count;
    logic [63:0] exp_pc;
  } vec_t;

  function automatic vec_t mk(input logic r, f, iv, input logic [63:0] pc, input logic ordy,
                              input logic ev, er, input int ec, input logic [63:0] epc);
    vec_t v;
    v.rst = r; v.flush = f; v.in_valid = iv; v.pc = pc; v.out_ready = ordy;
    v.exp_valid = ev; v.exp_ready = er; v.exp_count = ec; v.exp_pc = epc;
    return v;
  endfunction

  localparam int NV = 12;
  vec_t vecs[NV];

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] rpc;

    // Values are the state after the edge that applies the row's inputs.
    vecs[0]  = mk(1, 0, 0, 64'd0,   0, 0, 1, 0, 64'd0);
    vecs[1]  = mk(0, 0, 1, B,       0, 1, 1, 1, B);
    vecs[2]  = mk(0, 0, 1, B + 4,   0, 1, 1, 2, B);
    vecs[3]  = mk(0, 0, 1, B + 8,   0, 1, 1, 3, B);
    vecs[4]  = mk(0, 0, 1, B + 12,  0, 1, 0, 4, B);
    vecs[5]  = mk(0, 0, 1, B + 16,  0, 1, 0, 4, B);
    vecs[6]  = mk(0, 0, 1, B + 16,  1, 1, 1, 3, B + 4);
    vecs[7]  = mk(0, 0, 1, B + 16,  0, 1, 0, 4, B + 4);
    vecs[8]  = mk(0, 0, 0, 64'd0,   1, 1, 1, 3, B + 8);
    vecs[9]  = mk(0, 0, 0, 64'd0,   1, 1, 1, 2, B + 12);
    vecs[10] = mk(0, 0, 0, 64'd0,   1, 1, 1, 1, B + 16);
    vecs[11] = mk(0, 0, 0, 64'd0,   1, 0, 1, 0, 64'd0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].in_valid, vecs[i].pc, vecs[i].out_ready);
      step($sformatf("vec%0d model", i));
      chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ready,
              vecs[i].exp_count, vecs[i].exp_pc);
    end

    // Streaming: one per cycle, count pinned at 1, pointers wrap several times.
    drive(1, 0, 0, 64'd0, 0); step("stream rst");
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 1, B + 64'(4 * k), 1);
      step("stream model");
      chk_out($sformatf("stream%0d", k), 1, 1, 1, B + 64'(4 * k));
    end

    // Flush with a pending push and a completing pop.
    drive(1, 0, 0, 64'd0, 0); step("flush rst");
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, B + 64'(4 * k), 0); step("flush fill");
    end
    chk_out("flush pre", 1, 1, 3, B);
    drive(0, 1, 1, B + 64'h100, 1); step("flush model");
    chk_out("flush post", 0, 1, 0, 64'd0);
    drive(0, 0, 1, B + 64'h200, 0); step("flush target model");
    chk_out("flush target", 1, 1, 1, B + 64'h200);

    // Reset mid-stream with a push pending.
    drive(0, 0, 1, B + 64'h300, 0); step("midrst fill");
    chk_out("midrst pre", 1, 1, 2, B + 64'h200);
    drive(1, 0, 1, B + 64'h304, 0); step("midrst model");
    chk_out("midrst post", 0, 1, 0, 64'd0);
    drive(0, 0, 0, 64'd0, 1); step("midrst idle model");
    chk_out("midrst idle", 0, 1, 0, 64'd0);

    // Random traffic; fetch holds pc/inst until accepted unless it drops valid.
    rpc = B + 64'h1000;
    in_inst = $urandom;
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_pc     = rpc;
      step($sformatf("rand%0d", n));
      if (last_push) begin
        rpc     = rpc + 64'd4;
        in_inst = $urandom;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
Instruction queue between the instruction fetch unit and the decode unit.
- Captures fetched (pc, inst) pairs under a valid/ready handshake and presents them to decode in program order.
- Decouples fetch from decode stalls.
- Discards all buffered entries on a control-flow redirect (jump/branch flush) from execute.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
PC_W, 64, program counter width
INST_W, 32, instruction width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
flush  input  1  redirect from execute (same-cycle as jump_flag to fetch); discards queue contents
in_valid  input  1  fetch presents a valid pc/inst pair
in_ready  output  1  queue can accept a pair this cycle
in_pc  input  PC_W  pc of fetched instruction
in_inst  input  INST_W  fetched instruction word
out_valid  output  1  head entry is valid for decode
out_ready  input  1  decode consumes head entry this cycle
out_pc  output  PC_W  pc of head entry
out_inst  output  INST_W  instruction of head entry
count  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Storage: DEPTH-entry circular buffer. Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy counter is 0..DEPTH.
- Reset (rst=1 at rising edge): pointers=0, count=0. All outputs then read: out_valid=0, in_ready=1, out_pc=0, out_inst=0. Reset has priority over flush, push and pop; an operation in progress is abandoned.
- Push: occurs when in_valid & in_ready & !flush. Writes {in_pc,in_inst} at the write pointer, then increments it.
- Pop: occurs when out_valid & out_ready. Increments the read pointer.
- in_ready = (count < DEPTH), derived from state only. No ready pass-through when full: a pop in the same cycle does not enable a push.
- out_valid = (count != 0).
- out_pc/out_inst = head entry when out_valid=1; forced to 0 when out_valid=0.
- Latency: an entry pushed at edge N is visible on out_* after edge N (1 cycle min). There is no combinational path from in_* to out_*.
- Simultaneous push and pop (0 < count < DEPTH): count unchanged, both pointers advance.
- Full (count=DEPTH): in_ready=0; in_valid is ignored and fetch must hold its data.
- Empty (count=0): out_valid=0; out_ready is ignored.
- Flush, next edge:
  - count=0 and read pointer = write pointer.
  - A push presented in the flush cycle is dropped.
  - A pop handshake in the flush cycle completes: decode may take that head entry. The remaining entries are discarded.
  - out_valid=0 the cycle after a flush. The first post-flush entry (the redirected target) can be pushed the following cycle.
- in_valid may drop without a handshake (fetch redirected). The queue is unaffected.
- count never exceeds DEPTH nor underflows. Verify with assertions: count==DEPTH implies !push; count==0 implies !pop.

Test Plan:
1. Reset, then push pc=0x80000000 inst=0x00000413 with out_ready=0 -> out_valid=1 one cycle later, out_pc=0x80000000, out_inst=0x00000413, count=1; before that edge, out_valid=0 and out_pc=0.
2. Push 4 pairs (pc 0x80000000..0x8000000c), out_ready=0 -> count=4 and in_ready=0. A 5th in_valid with pc=0x80000010 is not accepted. Raising out_ready pops in order 0x80000000,0x80000004,...
3. Continuous in_valid=out_ready=1 for 20 cycles, pc stepping by 4 -> one instruction per cycle after a 1-cycle fill. count stays 1. Pointers wrap past DEPTH-1 with no lost or duplicated pc.
4. Three entries queued, assert flush with in_valid=1 (pc=0x80000100) and out_ready=1 -> head 0x80000000 consumed, 0x80000100 not stored. Next cycle count=0, out_valid=0. Push 0x80000200 the cycle after -> appears at output one cycle later.
5. Queue full, out_ready=1 and in_valid=1 in the same cycle -> only the pop occurs, count 4->3; the push is accepted the next cycle.
6. Assert rst mid-stream with count=2 and in_valid=1 -> after the edge count=0, out_valid=0, in_ready=1, out_pc=0, out_inst=0. The pushed data is not retained.
